alu_mc: RTL and testbench

- Parametrised-width, multi-cycle integer ALU. It is the registered successor to the datapath's combinational ALU.
- Adds valid/ready handshakes on input and output, and a registered result.
- Adds two iterative operations: unsigned multiply (shift-add) and unsigned divide (restoring). Both run through an internal FSM.
- Sits in the EXE stage. Stalls upstream via in_ready while a multi-cycle op is in flight or the output is back-pressured.

---
 rtl/alu_mc.sv | 175 +++++++++++++++++
 tb/tb_alu_mc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with valid/ready handshakes and registered outputs.
// Single-cycle ops complete in one cycle. MUL (shift-add) and DIVU (restoring) iterate WIDTH cycles.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  logic [0:0]         state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;

  logic               accept;
  logic               multi;
  logic               last_step;
  logic [SHW-1:0]     shamt;

  logic [WIDTH-1:0]   sc_result;
  logic [WIDTH-1:0]   sc_hi;
  logic               sc_dbz;
  logic               sc_ill;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign multi     = (op == OP_MUL) || ((op == OP_DIVU) && (val2 != '0));
  assign last_step = (state == CALC) && (cnt == CNT_LAST);
  assign shamt     = val2[SHW-1:0];

  // Single-cycle datapath; DIVU only lands here when the divisor is zero.
  always_comb begin
    sc_result = '0;
    sc_hi     = '0;
    sc_dbz    = 1'b0;
    sc_ill    = 1'b0;
    case (op)
      OP_ADD:  sc_result = val1 + val2;
      OP_SUB:  sc_result = val1 - val2;
      OP_AND:  sc_result = val1 & val2;
      OP_OR:   sc_result = val1 | val2;
      OP_XOR:  sc_result = val1 ^ val2;
      OP_NOR:  sc_result = ~(val1 | val2);
      OP_SLL:  sc_result = val1 << shamt;
      OP_SRL:  sc_result = val1 >> shamt;
      OP_SRA:  sc_result = $signed(val1) >>> shamt;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(val1) < $signed(val2))};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (val1 < val2)};
      OP_MUL:  sc_result = '0;
      OP_DIVU: begin
        sc_result = '1;
        sc_hi     = val1;
        sc_dbz    = 1'b1;
      end
      default: sc_ill = 1'b1;
    endcase
  end

  // acc holds {high, low}: product halves for MUL, {remainder, quotient/dividend} for DIVU.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, opnd};
    if (rem_trial[WIDTH])
      div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {rem_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    step_next = is_div ? div_next : mul_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && multi) begin
            state  <= CALC;
            cnt    <= '0;
            is_div <= (op == OP_DIVU);
            acc    <= {{WIDTH{1'b0}}, ((op == OP_DIVU) ? val1 : val2)};
            opnd   <= (op == OP_DIVU) ? val2 : val1;
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt + CNT_ONE;
          if (last_step) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A multi-cycle accept implies the old result is released (or absent), so out_valid simply clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (accept && !multi) begin
      out_valid   <= 1'b1;
      result      <= sc_result;
      result_hi   <= sc_hi;
      zero        <= (sc_result == '0);
      div_by_zero <= sc_dbz;
      illegal_op  <= sc_ill;
    end else if (accept) begin
      out_valid <= 1'b0;
    end else if (last_step) begin
      out_valid   <= 1'b1;
      result      <= step_next[WIDTH-1:0];
      result_hi   <= step_next[2*WIDTH-1:WIDTH];
      zero        <= (step_next[WIDTH-1:0] == '0);
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: an 8-bit instance for most scenarios
// and a 32-bit instance for the wide multiply.
module tb_alu_mc;

  logic clk;
  logic rst;

  logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [3:0] n_op;
  logic [7:0] n_val1, n_val2, n_result, n_result_hi;
  logic       n_zero, n_dbz, n_ill;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [3:0]  w_op;
  logic [31:0] w_val1, w_val2, w_result, w_result_hi;
  logic        w_zero, w_dbz, w_ill;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       z;
  } vec_t;

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .op(n_op),
    .val1(n_val1), .val2(n_val2),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .result(n_result), .result_hi(n_result_hi),
    .zero(n_zero), .div_by_zero(n_dbz), .illegal_op(n_ill)
  );

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
    .val1(w_val1), .val2(w_val2),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .result(w_result), .result_hi(w_result_hi),
    .zero(w_zero), .div_by_zero(w_dbz), .illegal_op(w_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", n_out_valid); end
    checks++; if (n_result !== 8'h00) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00", n_result); end
    checks++; if (n_result_hi !== 8'h00) begin errors++; $display("[TB] FAIL reset_result_hi: got %h expected 00", n_result_hi); end
    checks++; if ({n_zero, n_dbz, n_ill} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {n_zero, n_dbz, n_ill}); end
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", n_in_ready); end
    checks++; if (w_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wide_out_valid: got %b expected 0", w_out_valid); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_sweep();
    vec_t v [11];
    v[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1};
    v[1]  = '{4'd1,  8'h00, 8'h01, 8'hFF, 1'b0};
    v[2]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 1'b0};
    v[3]  = '{4'd3,  8'hF0, 8'h0F, 8'hFF, 1'b0};
    v[4]  = '{4'd4,  8'hF0, 8'hFF, 8'h0F, 1'b0};
    v[5]  = '{4'd5,  8'hF0, 8'h0F, 8'h00, 1'b1};
    v[6]  = '{4'd6,  8'h01, 8'h09, 8'h02, 1'b0};
    v[7]  = '{4'd7,  8'h80, 8'h03, 8'h10, 1'b0};
    v[8]  = '{4'd9,  8'hFF, 8'h01, 8'h01, 1'b0};
    v[9]  = '{4'd10, 8'hFF, 8'h01, 8'h00, 1'b1};
    v[10] = '{4'd8,  8'h80, 8'h03, 8'hF0, 1'b0};
    n_out_ready = 1'b1;
    n_in_valid = 1'b1; n_op = v[0].op; n_val1 = v[0].a; n_val2 = v[0].b;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checks++; if (n_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sweep%0d_out_valid: got %b expected 1", i, n_out_valid); end
      checks++; if (n_result !== v[i].r) begin errors++; $display("[TB] FAIL sweep%0d_result: got %h expected %h", i, n_result, v[i].r); end
      checks++; if (n_zero !== v[i].z) begin errors++; $display("[TB] FAIL sweep%0d_zero: got %b expected %b", i, n_zero, v[i].z); end
      checks++; if (n_result_hi !== 8'h00) begin errors++; $display("[TB] FAIL sweep%0d_result_hi: got %h expected 00", i, n_result_hi); end
      checks++; if (n_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL sweep%0d_in_ready: got %b expected 1", i, n_in_ready); end
      if (i < 10) begin
        n_op = v[i+1].op; n_val1 = v[i+1].a; n_val2 = v[i+1].b;
      end else begin
        n_in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    bit seen;
    n_in_valid = 1'b1; n_op = 4'd11; n_val1 = 8'h0F; n_val2 = 8'h11;
    @(negedge clk);
    n_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_out_valid: got %b expected 0", n_out_valid); end
    checks++; if (n_result !== 8'h00) begin errors++; $display("[TB] FAIL abort_result: got %h expected 00", n_result); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_ready: got %b expected 1", n_in_ready); end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (n_out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_result: got %b expected 0", seen); end
  endtask

  task automatic test_mul();
    n_in_valid = 1'b1; n_op = 4'd11; n_val1 = 8'hFF; n_val2 = 8'hFF;
    @(negedge clk);
    n_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({n_in_ready, n_out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL mul_busy%0d: got %b expected 00", i, {n_in_ready, n_out_valid}); end
      @(negedge clk);
    end
    checks++; if (n_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mul_out_valid: got %b expected 1", n_out_valid); end
    checks++; if (n_result !== 8'h01) begin errors++; $display("[TB] FAIL mul_result: got %h expected 01", n_result); end
    checks++; if (n_result_hi !== 8'hFE) begin errors++; $display("[TB] FAIL mul_result_hi: got %h expected fe", n_result_hi); end
    checks++; if (n_zero !== 1'b0) begin errors++; $display("[TB] FAIL mul_zero: got %b expected 0", n_zero); end
    @(negedge clk);
  endtask

  task automatic test_divu();
    n_in_valid = 1'b1; n_op = 4'd12; n_val1 = 8'hC8; n_val2 = 8'h07;
    @(negedge clk);
    n_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({n_in_ready, n_out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL div_busy%0d: got %b expected 00", i, {n_in_ready, n_out_valid}); end
      @(negedge clk);
    end
    checks++; if (n_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL div_out_valid: got %b expected 1", n_out_valid); end
    checks++; if (n_result !== 8'h1C) begin errors++; $display("[TB] FAIL div_quotient: got %h expected 1c", n_result); end
    checks++; if (n_result_hi !== 8'h04) begin errors++; $display("[TB] FAIL div_remainder: got %h expected 04", n_result_hi); end
    checks++; if (n_dbz !== 1'b0) begin errors++; $display("[TB] FAIL div_dbz_clear: got %b expected 0", n_dbz); end
    n_in_valid = 1'b1; n_op = 4'd12; n_val1 = 8'h55; n_val2 = 8'h00;
    @(negedge clk);
    n_in_valid = 1'b0;
    checks++; if (n_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dbz_out_valid: got %b expected 1", n_out_valid); end
    checks++; if (n_result !== 8'hFF) begin errors++; $display("[TB] FAIL dbz_result: got %h expected ff", n_result); end
    checks++; if (n_result_hi !== 8'h55) begin errors++; $display("[TB] FAIL dbz_result_hi: got %h expected 55", n_result_hi); end
    checks++; if (n_dbz !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag: got %b expected 1", n_dbz); end
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dbz_in_ready: got %b expected 1", n_in_ready); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    n_out_ready = 1'b0;
    n_in_valid = 1'b1; n_op = 4'd0; n_val1 = 8'h03; n_val2 = 8'h04;
    @(negedge clk);
    n_in_valid = 1'b0; n_val1 = 8'hAA; n_val2 = 8'h55;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({n_out_valid, n_in_ready, n_result} !== {2'b10, 8'h07}) begin errors++; $display("[TB] FAIL hold%0d: got v=%b r=%b res=%h expected v=1 r=0 res=07", i, n_out_valid, n_in_ready, n_result); end
      @(negedge clk);
    end
    n_out_ready = 1'b1;
    n_in_valid = 1'b1; n_op = 4'd0; n_val1 = 8'h01; n_val2 = 8'h01;
    #1;
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", n_in_ready); end
    @(negedge clk);
    n_in_valid = 1'b0;
    checks++; if ({n_out_valid, n_result} !== {1'b1, 8'h02}) begin errors++; $display("[TB] FAIL release_new: got v=%b res=%h expected v=1 res=02", n_out_valid, n_result); end
    @(negedge clk);
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_drop: got %b expected 0", n_out_valid); end
  endtask

  task automatic test_illegal();
    n_in_valid = 1'b1; n_op = 4'd14; n_val1 = 8'h05; n_val2 = 8'h03;
    @(negedge clk);
    n_in_valid = 1'b0;
    checks++; if (n_ill !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag: got %b expected 1", n_ill); end
    checks++; if ({n_result, n_result_hi} !== 16'h0000) begin errors++; $display("[TB] FAIL illegal_result: got %h expected 0000", {n_result, n_result_hi}); end
    checks++; if (n_zero !== 1'b1) begin errors++; $display("[TB] FAIL illegal_zero: got %b expected 1", n_zero); end
    n_in_valid = 1'b1; n_op = 4'd3; n_val1 = 8'h05; n_val2 = 8'h03;
    @(negedge clk);
    n_in_valid = 1'b0;
    checks++; if ({n_ill, n_result} !== {1'b0, 8'h07}) begin errors++; $display("[TB] FAIL illegal_clear: got ill=%b res=%h expected ill=0 res=07", n_ill, n_result); end
    @(negedge clk);
  endtask

  task automatic test_mul_wide();
    w_in_valid = 1'b1; w_op = 4'd11; w_val1 = 32'hFFFF_FFFF; w_val2 = 32'h0000_0002;
    @(negedge clk);
    w_in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++; if ({w_in_ready, w_out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL wmul_busy%0d: got %b expected 00", i, {w_in_ready, w_out_valid}); end
      @(negedge clk);
    end
    checks++; if (w_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL wmul_out_valid: got %b expected 1", w_out_valid); end
    checks++; if (w_result !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL wmul_result: got %h expected fffffffe", w_result); end
    checks++; if (w_result_hi !== 32'h0000_0001) begin errors++; $display("[TB] FAIL wmul_result_hi: got %h expected 00000001", w_result_hi); end
    checks++; if ({w_zero, w_dbz, w_ill} !== 3'b000) begin errors++; $display("[TB] FAIL wmul_flags: got %b expected 000", {w_zero, w_dbz, w_ill}); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    n_in_valid = 1'b0; n_op = 4'd0; n_val1 = 8'h00; n_val2 = 8'h00; n_out_ready = 1'b1;
    w_in_valid = 1'b0; w_op = 4'd0; w_val1 = 32'h0; w_val2 = 32'h0; w_out_ready = 1'b1;
    test_reset();
    test_single_sweep();
    test_reset_mid_calc();
    test_mul();
    test_divu();
    test_back_to_back();
    test_illegal();
    test_mul_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
